proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Autonomous instruction sequencer for the 9-bit mv/mvi/add/sub processor.
- Fetches instruction words from a synchronous program ROM, drives the processor's DIN/Run inputs, waits for Done and advances a program counter.
- Handles the two-word mvi format, a sequencer-level HALT opcode, illegal opcodes and a Done timeout.
- Sits between the program ROM and the processor; the processor shares Clock and Resetn.

Parameters:
- AW, 8, program ROM address width; PC wraps modulo 2^AW.
- TIMEOUT, 8, maximum cycles spent in WAIT without Done before an error (1..255).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin execution at start_addr.
- stop  in  1  one-cycle pulse: halt at next instruction boundary.
- start_addr  in  AW  initial PC, sampled on accepted start.
- mem_addr  out  AW  ROM read address.
- mem_rd  out  1  ROM read enable; data valid on mem_rdata the following cycle.
- mem_rdata  in  9  ROM read data.
- DIN  out  9  processor data input, registered.
- Run  out  1  processor Run; high exactly one cycle per issued instruction.
- Done  in  1  processor Done.
- busy  out  1  high in every state except IDLE.
- pc  out  AW  current PC.
- instr_count  out  16  instructions completed since last accepted start; saturates at 16'hFFFF.
- err_timeout  out  1  sticky; cleared on accepted start.
- err_illegal  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset values: DIN=0, Run=0, mem_rd=0, mem_addr=0, pc=0, instr_count=0, busy=0, both error flags 0; state IDLE.
- Opcode field is word bits [8:6]:
  - 000 mv, 001 mvi, 010 add, 011 sub: issued to the processor.
  - 111 HALT: not issued; go to IDLE.
  - 100..110 illegal: not issued; set err_illegal; go to IDLE.
- IDLE:
  - Accepted start (start=1 and stop=0): pc<=start_addr, clear instr_count and both error flags, go to FETCH.
  - start and stop asserted together: stay IDLE.
- FETCH: mem_addr=pc, mem_rd=1 -> LATCH.
- LATCH:
  - mem_rdata holds the instruction; din_q<=mem_rdata.
  - Drive mem_addr=pc+1, mem_rd=1 (speculative immediate prefetch).
  - Go to ISSUE if the opcode is legal; otherwise take the HALT or illegal action above.
- ISSUE:
  - Run=1 while DIN carries the instruction; the processor latches IR at this edge.
  - If mvi: din_q<=mem_rdata, so the immediate is on DIN in the processor's T1 cycle, and pc<=pc+2.
  - Otherwise: pc<=pc+1.
  - Go to WAIT; reset the timeout counter.
- WAIT:
  - Run=0; DIN holds its value.
  - On Done=1: instr_count+=1, then go to IDLE if a stop is pending, else FETCH.
  - If the counter reaches TIMEOUT without Done: set err_timeout, go to IDLE.
- Latency: mv/mvi take 4 cycles from FETCH to the next FETCH (FETCH, LATCH, ISSUE, WAIT with Done in the first WAIT cycle); add/sub take 6.
- stop pulse in any non-IDLE state sets stop_pend; it takes effect only on Done in WAIT (never mid-instruction). stop_pend is cleared on entry to IDLE. stop in IDLE is ignored.
- start while busy: ignored.
- PC arithmetic is modulo 2^AW. An mvi at address 2^AW-1 fetches its immediate from address 0, and pc becomes 1.
- Done seen outside WAIT: ignored.
- Resetn low mid-instruction: immediate return to reset values, no pending state retained.

Decomposition:
- Shared package proc_pkg: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT=3'b111), state encoding (IDLE, FETCH, LATCH, ISSUE, WAIT), opcode field position [8:6].
- Single flat module; the timeout counter and PC adder are inline, no sub-module.

Test Plan:
- ROM[0]=mvi R0 (9'b001000000), ROM[1]=9'd5, ROM[2]=HALT; start, start_addr=0 -> Run pulses once; DIN=9'd5 the cycle after Run; processor R0=5; busy falls with pc=3, instr_count=1.
- ROM: mvi R1,3; mvi R2,4; add R1,R2 (9'b010001010); HALT -> R1=7, instr_count=3, Run pulses exactly 3 times, no error flags.
- ROM[0]=9'b100000000 (illegal) -> err_illegal=1, Run never asserted, returns to IDLE with pc=0.
- Done held at 0 by the bench after issuing mv -> err_timeout=1 after exactly TIMEOUT=8 WAIT cycles, busy=0, instr_count=0.
- stop pulsed during WAIT of an add -> add completes (Done seen, instr_count+1), then IDLE; the next instruction is never fetched.
- AW=8, start_addr=8'hFF, ROM[FF]=mvi R3, ROM[00]=9'h1AB, ROM[01]=HALT -> R3=9'h1AB, pc wraps to 8'h02 at halt. Also: Resetn asserted during WAIT -> all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the mv/mvi/add/sub processor sequencer:
// instruction word layout, opcodes and sequencer state encoding.
package proc_pkg;

  localparam int unsigned WORD_W = 9;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned OP_HI  = 8;
  localparam int unsigned OP_LO  = 6;

  localparam logic [OP_W-1:0] OP_MV   = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_e;

  function automatic logic [OP_W-1:0] opcode(input logic [WORD_W-1:0] w);
    return w[OP_HI:OP_LO];
  endfunction

  // Opcodes the processor itself understands
  function automatic logic op_issuable(input logic [OP_W-1:0] op);
    return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Program ROM read port plus processor DIN/Run/Done handshake.
interface proc_sequencer_if
  import proc_pkg::*;
#(
  parameter int unsigned AW = 8
);

  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] DIN;
  logic              Run;
  logic              Done;

  modport master (
    output mem_addr, mem_rd, DIN, Run,
    input  mem_rdata, Done
  );

  modport slave (
    input  mem_addr, mem_rd, DIN, Run,
    output mem_rdata, Done
  );

endinterface

// File: rtl/proc_sequencer.sv
// Autonomous instruction sequencer: fetches words from a synchronous ROM,
// issues them to the processor over DIN/Run and waits for Done.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [AW-1:0]          start_addr,
  proc_sequencer_if.master       bus,
  output logic                   busy,
  output logic [AW-1:0]          pc,
  output logic [15:0]            instr_count,
  output logic                   err_timeout,
  output logic                   err_illegal
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = 8;

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [WORD_W-1:0]  din_q, din_d;
  logic               run_q, run_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_tmo_q, err_tmo_d;
  logic               err_ill_q, err_ill_d;
  logic               stop_pend_q, stop_pend_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [OP_W-1:0]    op_c;

  assign op_c = opcode(bus.mem_rdata);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      din_q       <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      err_tmo_q   <= 1'b0;
      err_ill_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      din_q       <= din_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      err_tmo_q   <= err_tmo_d;
      err_ill_q   <= err_ill_d;
      stop_pend_q <= stop_pend_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    din_d       = din_q;
    run_d       = 1'b0;
    busy_d      = 1'b0;
    cnt_d       = cnt_q;
    err_tmo_d   = err_tmo_q;
    err_ill_d   = err_ill_q;
    stop_pend_d = stop_pend_q;
    tmo_d       = tmo_q;

    if ((state_q != IDLE) && stop) stop_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          pc_d      = start_addr;
          cnt_d     = '0;
          err_tmo_d = 1'b0;
          err_ill_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        din_d = bus.mem_rdata;
        if (op_issuable(op_c)) begin
          state_d = ISSUE;
        end else if (op_c == OP_HALT) begin
          pc_d    = pc_q + AW'(1);
          state_d = IDLE;
        end else begin
          err_ill_d = 1'b1;
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        // Immediate was prefetched in LATCH; present it for the processor's T1
        if (opcode(din_q) == OP_MVI) begin
          din_d = bus.mem_rdata;
          pc_d  = pc_q + AW'(2);
        end else begin
          pc_d  = pc_q + AW'(1);
        end
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.Done) begin
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = (stop_pend_q || stop) ? IDLE : FETCH;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) stop_pend_d = 1'b0;

    // Bus outputs are registered, so they follow the state being entered
    busy_d = (state_d != IDLE);
    run_d  = (state_d == ISSUE);
    if (state_d == FETCH) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == LATCH) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = pc_q + AW'(1);
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.DIN      = din_q;
  assign bus.Run      = run_q;
  assign busy         = busy_q;
  assign pc           = pc_q;
  assign instr_count  = cnt_q;
  assign err_timeout  = err_tmo_q;
  assign err_illegal  = err_ill_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a ROM and a small mv/mvi/add/sub
// processor model attached to the sequencer bus.
module tb_proc_sequencer;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic        stop;
  logic [7:0]  start_addr;
  logic        busy;
  logic [7:0]  pc;
  logic [15:0] instr_count;
  logic        err_timeout;
  logic        err_illegal;

  proc_sequencer_if #(.AW(8)) bif ();

  proc_sequencer #(.AW(8), .TIMEOUT(8)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .start       (start),
    .stop        (stop),
    .start_addr  (start_addr),
    .bus         (bif),
    .busy        (busy),
    .pc          (pc),
    .instr_count (instr_count),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Program ROM: one-cycle read latency
  logic [8:0] rom [256];
  always @(posedge Clock) if (bif.mem_rd) bif.mem_rdata <= rom[bif.mem_addr];

  // Processor model: mv/mvi finish in T1, add/sub in T3
  logic [8:0] R [8];
  logic [8:0] ir, a_r, g_r;
  logic [1:0] tstep;
  logic       hang;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= 2'd0;
      ir    <= 9'd0;
    end else begin
      case (tstep)
        2'd0: if (bif.Run) begin ir <= bif.DIN; tstep <= 2'd1; end
        2'd1: begin
          case (ir[8:6])
            3'b000:  begin R[ir[5:3]] <= R[ir[2:0]]; tstep <= 2'd0; end
            3'b001:  begin R[ir[5:3]] <= bif.DIN;    tstep <= 2'd0; end
            default: begin a_r <= R[ir[5:3]];        tstep <= 2'd2; end
          endcase
        end
        2'd2: begin
          g_r   <= ir[6] ? a_r - R[ir[2:0]] : a_r + R[ir[2:0]];
          tstep <= 2'd3;
        end
        default: begin R[ir[5:3]] <= g_r; tstep <= 2'd0; end
      endcase
    end
  end

  assign bif.Done = !hang && ((tstep == 2'd1 && ir[8:7] == 2'b00) || tstep == 2'd3);

  // Activity monitors sampled at the active edge (pre-update values)
  int         run_cnt  = 0;
  int         busy_cyc = 0;
  logic       prev_run = 1'b0;
  logic [8:0] din_after_run = 9'd0;
  always @(posedge Clock) begin
    run_cnt  <= run_cnt + int'(bif.Run);
    busy_cyc <= busy_cyc + int'(busy);
    prev_run <= bif.Run;
    if (prev_run) din_after_run <= bif.DIN;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int run0, busy0;

  task automatic kick(input logic [7:0] addr);
    @(negedge Clock);
    run0       = run_cnt;
    busy0      = busy_cyc;
    start_addr = addr;
    start      = 1'b1;
    @(negedge Clock);
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    if (!ok) check({tag, "_idle_bound"}, 32'd0, 32'd1);
  endtask

  task automatic wait_run(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bif.Run) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    if (!ok) check({tag, "_run_bound"}, 32'd0, 32'd1);
  endtask

  localparam logic [8:0] HALT_W = 9'b111_000_000;

  initial begin
    Resetn = 1'b0; start = 1'b0; stop = 1'b0; start_addr = 8'd0; hang = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = HALT_W;
    repeat (3) @(negedge Clock);

    check("rst_busy",  32'(busy), 32'd0);
    check("rst_run",   32'(bif.Run), 32'd0);
    check("rst_memrd", 32'(bif.mem_rd), 32'd0);
    check("rst_addr",  32'(bif.mem_addr), 32'd0);
    check("rst_din",   32'(bif.DIN), 32'd0);
    check("rst_pc",    32'(pc), 32'd0);
    check("rst_cnt",   32'(instr_count), 32'd0);
    check("rst_errs",  32'({err_timeout, err_illegal}), 32'd0);
    Resetn = 1'b1;

    // mvi R0,5 ; HALT
    rom[0] = 9'b001_000_000; rom[1] = 9'd5; rom[2] = HALT_W;
    kick(8'h00); wait_idle("t1");
    check("t1_r0",   32'(R[0]), 32'd5);
    check("t1_din",  32'(din_after_run), 32'd5);
    check("t1_runs", 32'(run_cnt - run0), 32'd1);
    check("t1_pc",   32'(pc), 32'd3);
    check("t1_cnt",  32'(instr_count), 32'd1);
    check("t1_cyc",  32'(busy_cyc - busy0), 32'd6);

    // mvi R1,3 ; mvi R2,4 ; add R1,R2 ; HALT
    rom[0] = 9'b001_001_000; rom[1] = 9'd3;
    rom[2] = 9'b001_010_000; rom[3] = 9'd4;
    rom[4] = 9'b010_001_010; rom[5] = HALT_W;
    kick(8'h00); wait_idle("t2");
    check("t2_r1",   32'(R[1]), 32'd7);
    check("t2_runs", 32'(run_cnt - run0), 32'd3);
    check("t2_cnt",  32'(instr_count), 32'd3);
    check("t2_pc",   32'(pc), 32'd6);
    check("t2_cyc",  32'(busy_cyc - busy0), 32'd16);
    check("t2_errs", 32'({err_timeout, err_illegal}), 32'd0);

    // Illegal opcode at address 0
    rom[0] = 9'b100_000_000;
    kick(8'h00); wait_idle("t3");
    check("t3_ill",  32'(err_illegal), 32'd1);
    check("t3_runs", 32'(run_cnt - run0), 32'd0);
    check("t3_pc",   32'(pc), 32'd0);
    check("t3_cnt",  32'(instr_count), 32'd0);

    // mv R0,R1 with Done withheld -> timeout after 8 WAIT cycles
    rom[0] = 9'b000_000_001; hang = 1'b1;
    kick(8'h00); wait_idle("t4");
    hang = 1'b0;
    check("t4_tmo",  32'(err_timeout), 32'd1);
    check("t4_ill",  32'(err_illegal), 32'd0);
    check("t4_cnt",  32'(instr_count), 32'd0);
    check("t4_cyc",  32'(busy_cyc - busy0), 32'd11);
    check("t4_busy", 32'(busy), 32'd0);

    // start together with stop is not accepted
    @(negedge Clock); start = 1'b1; stop = 1'b1;
    @(negedge Clock); start = 1'b0; stop = 1'b0;
    @(negedge Clock);
    check("t5_nostart", 32'(busy), 32'd0);

    // add R1,R2 with stop during WAIT; next instruction must not be fetched
    rom[0] = 9'b010_001_010; rom[1] = 9'b001_011_000; rom[2] = 9'd9; rom[3] = HALT_W;
    kick(8'h00); wait_run("t5");
    @(negedge Clock); stop = 1'b1;
    @(negedge Clock); stop = 1'b0;
    wait_idle("t5");
    check("t5_r1",   32'(R[1]), 32'd11);
    check("t5_cnt",  32'(instr_count), 32'd1);
    check("t5_runs", 32'(run_cnt - run0), 32'd1);
    check("t5_pc",   32'(pc), 32'd1);
    check("t5_tmo",  32'(err_timeout), 32'd0);

    // mvi at 0xFF takes its immediate from 0x00
    rom[8'hFF] = 9'b001_011_000; rom[0] = 9'h1AB; rom[1] = HALT_W;
    kick(8'hFF); wait_idle("t6");
    check("t6_r3",  32'(R[3]), 32'h1AB);
    check("t6_pc",  32'(pc), 32'h02);
    check("t6_cnt", 32'(instr_count), 32'd1);

    // Reset asserted during WAIT of an add at 0x10
    rom[8'h10] = 9'b010_001_010;
    kick(8'h10); wait_run("t7");
    @(negedge Clock);
    check("t7_pre_pc", 32'(pc), 32'h11);
    Resetn = 1'b0;
    #1;
    check("t7_busy",  32'(busy), 32'd0);
    check("t7_pc",    32'(pc), 32'd0);
    check("t7_addr",  32'(bif.mem_addr), 32'd0);
    check("t7_din",   32'(bif.DIN), 32'd0);
    check("t7_runrd", 32'({bif.Run, bif.mem_rd}), 32'd0);
    @(negedge Clock); Resetn = 1'b1;
    repeat (4) @(negedge Clock);
    check("t7_stay_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
